// File: rtl/triloc_pkg.sv
// Purpose: shared widths, FSM states and step count for the trilateration select stage.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package triloc_pkg;

    // Anchor coordinate width; candidates are N+2 signed, radius N+1 unsigned.
    localparam int N         = 8;
    localparam int CW        = N + 2;      // candidate coordinate width
    localparam int DW        = N + 3;      // signed difference width
    localparam int QW        = 2 * N + 4;  // unsigned square width
    localparam int SW        = 2 * N + 5;  // distance-sum / residual width
    localparam int MUL_STEPS = 5;          // dx1^2, dy1^2, dx2^2, dy2^2, rM^2

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        CMP  = 2'd2,
        OUT  = 2'd3
    } state_t;

endpackage

// File: rtl/intersection_select_seq_sq_mul_shared.sv
// Purpose: registered signed squarer shared across all multiply steps.
// Latency: 1 cycle, operand presented before edge, square valid after it.
// Backpressure: none; loads a new square every cycle.
module sq_mul_shared
    import triloc_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic signed [DW-1:0] i_op,
    output logic        [QW-1:0] o_sq
);

    logic signed [QW-1:0] w_op_ext;
    logic signed [QW-1:0] w_sq;
    logic        [QW-1:0] r_sq;

    // The true square of a DW operand fits in QW bits, so a QW-wide product is exact.
    assign w_op_ext = QW'(i_op);
    assign w_sq     = w_op_ext * w_op_ext;
    assign o_sq     = r_sq;

    // Square register; the result is always non-negative.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sq <= '0;
        end else begin
            r_sq <= w_sq;
        end
    end

endmodule

// File: rtl/intersection_select_seq.sv
// Purpose: pick the intersection candidate whose distance to anchor M best matches rM, report residual/fit.
// Latency: accept at edge T, result valid after edge T+6; one bundle in flight, 8-cycle peak period.
// Backpressure: out_ready low holds the result and keeps in_ready low indefinitely.
module intersection_select_seq
    import triloc_pkg::*;
#(
    parameter int unsigned TOL = 64
)
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic signed [CW-1:0] x1P,
    input  logic signed [CW-1:0] y1P,
    input  logic signed [CW-1:0] x2P,
    input  logic signed [CW-1:0] y2P,
    input  logic signed [N-1:0]  xM,
    input  logic signed [N-1:0]  yM,
    input  logic        [N:0]    rM,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic signed [CW-1:0] xP,
    output logic signed [CW-1:0] yP,
    output logic                 out_sel,
    output logic        [SW-1:0] out_err,
    output logic                 out_tie,
    output logic                 out_fit
);

    localparam logic [SW-1:0] TOL_V    = SW'(TOL);
    localparam logic [2:0]    CNT_LAST = 3'(MUL_STEPS - 1);

    state_t r_state, w_state_nxt;
    logic [2:0] r_cnt, w_cnt_nxt;

    logic signed [CW-1:0] r_x1, r_y1, r_x2, r_y2;
    logic signed [N-1:0]  r_xm, r_ym;
    logic        [N:0]    r_rm;

    logic        [QW-1:0] r_sq_dx1, r_sq_dy1, r_sq_dx2, r_sq_dy2;
    logic signed [DW-1:0] w_op;
    logic        [QW-1:0] w_sq;

    logic [SW-1:0] w_d1, w_d2, w_r2, w_e1, w_e2;
    logic          w_sel;
    logic          w_accept;

    assign in_ready  = (r_state == IDLE);
    assign out_valid = (r_state == OUT);
    assign w_accept  = in_valid && in_ready;

    // State and multiply-step counter register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Next-state logic: IDLE -> MUL (5 steps) -> CMP -> OUT -> IDLE.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            IDLE: begin
                if (in_valid) begin
                    w_state_nxt = MUL;
                    w_cnt_nxt   = '0;
                end
            end
            MUL: begin
                if (r_cnt == CNT_LAST) begin
                    w_state_nxt = CMP;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + 3'd1;
                end
            end
            CMP:     w_state_nxt = OUT;
            OUT: begin
                if (out_ready) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Capture the whole input bundle on accept; inputs are ignored afterwards.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_x1 <= '0;
            r_y1 <= '0;
            r_x2 <= '0;
            r_y2 <= '0;
            r_xm <= '0;
            r_ym <= '0;
            r_rm <= '0;
        end else if (w_accept) begin
            r_x1 <= x1P;
            r_y1 <= y1P;
            r_x2 <= x2P;
            r_y2 <= y2P;
            r_xm <= xM;
            r_ym <= yM;
            r_rm <= rM;
        end
    end

    // Squarer operand mux: step k selects the k-th term; rM is zero-extended as it is unsigned.
    always_comb begin
        w_op = '0;
        case (r_cnt)
            3'd0:    w_op = DW'(r_x1) - DW'(r_xm);
            3'd1:    w_op = DW'(r_y1) - DW'(r_ym);
            3'd2:    w_op = DW'(r_x2) - DW'(r_xm);
            3'd3:    w_op = DW'(r_y2) - DW'(r_ym);
            default: w_op = signed'({{(DW-N-1){1'b0}}, r_rm});
        endcase
    end

    sq_mul_shared u_sq (
        .clk  (clk),
        .rst  (rst),
        .i_op (w_op),
        .o_sq (w_sq)
    );

    // The squarer output lags the operand by one edge, so step k stores square k-1.
    // The last square (rM^2) is consumed straight from the squarer during CMP.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sq_dx1 <= '0;
            r_sq_dy1 <= '0;
            r_sq_dx2 <= '0;
            r_sq_dy2 <= '0;
        end else if (r_state == MUL) begin
            case (r_cnt)
                3'd1:    r_sq_dx1 <= w_sq;
                3'd2:    r_sq_dy1 <= w_sq;
                3'd3:    r_sq_dx2 <= w_sq;
                3'd4:    r_sq_dy2 <= w_sq;
                default: ;
            endcase
        end
    end

    // Residuals |d - rM^2| for both candidates; all terms fit SW bits unsigned.
    always_comb begin
        w_d1  = SW'(r_sq_dx1) + SW'(r_sq_dy1);
        w_d2  = SW'(r_sq_dx2) + SW'(r_sq_dy2);
        w_r2  = SW'(w_sq);
        w_e1  = (w_d1 >= w_r2) ? (w_d1 - w_r2) : (w_r2 - w_d1);
        w_e2  = (w_d2 >= w_r2) ? (w_d2 - w_r2) : (w_r2 - w_d2);
        w_sel = (w_e2 < w_e1);
    end

    // Result registers, loaded in CMP and held through OUT; a tie keeps candidate 1.
    always_ff @(posedge clk) begin
        if (rst) begin
            xP      <= '0;
            yP      <= '0;
            out_sel <= 1'b0;
            out_err <= '0;
            out_tie <= 1'b0;
            out_fit <= 1'b0;
        end else if (r_state == CMP) begin
            xP      <= w_sel ? r_x2 : r_x1;
            yP      <= w_sel ? r_y2 : r_y1;
            out_sel <= w_sel;
            out_err <= w_sel ? w_e2 : w_e1;
            out_tie <= (w_e1 == w_e2);
            out_fit <= (w_sel ? w_e2 : w_e1) <= TOL_V;
        end
    end

endmodule
